twos_comp_share_ctrl: RTL and testbench
=======================================

Name: twos_comp_share_ctrl

Overview:
- Round-robin scheduler that shares one two's-complement negation unit among N_REQ requesters.
- Each requester uses a valid/ready handshake. Results are returned on a single registered response channel tagged with the requester ID.
- Sits between multiple arithmetic clients and the shared converter datapath so that only one converter instance is needed.

Parameters:
- WIDTH, 8, data width of operands and results.
- N_REQ, 4, number of requesters (≥2).
- CNT_W, 16, width of completed-conversion counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_data  input  N_REQ x WIDTH  per-requester operand (unpacked array).
- req_ready  output  N_REQ  per-requester grant/accept, at most one bit high.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_data  output  WIDTH  two's complement (~x+1, mod 2^WIDTH) of granted operand.
- resp_id  output  $clog2(N_REQ)  index of requester served.
- resp_ovf  output  1  operand was most-negative value (1 followed by zeros); negation not representable.
- conv_count  output  CNT_W  number of responses consumed, saturating.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; resp_valid=0, resp_data=0, resp_id=0, resp_ovf=0, conv_count=0.
  - RR pointer=0, so requester 0 has highest priority.
  - req_ready is all-zero while rst is high.
- States are IDLE and HOLD.
- accept_ok = (state==IDLE) or (state==HOLD and resp_ready).
- Grant: when accept_ok and any req_valid, the RR winner w is the first valid index searching from ptr upward, wrapping at N_REQ.
  - req_ready[w]=1, combinationally in the same cycle. All other req_ready bits are 0.
  - If accept_ok is false, req_ready is all 0.
- On a handshake (req_valid[w] & req_ready[w]) at edge T:
  - resp_data <= ~req_data[w]+1 truncated to WIDTH.
  - resp_id <= w.
  - resp_ovf <= (req_data[w]=={1'b1,{WIDTH-1{0}}}).
  - resp_valid <= 1, state <= HOLD, ptr <= (w+1) mod N_REQ.
- Latency is exactly 1 cycle: resp_valid is high in cycle T+1.
- HOLD:
  - resp_valid=1, and resp_data/resp_id/resp_ovf stay stable until resp_ready.
  - resp_ready with a new grant: load the new result, stay in HOLD. Throughput is 1 result/cycle.
  - resp_ready with no valid request: state <= IDLE, resp_valid <= 0. Data/id/ovf hold their last values.
  - No resp_ready: no grant, everything holds.
- conv_count increments on each resp_valid & resp_ready. It saturates at all-ones, with no wrap.
- Zero operand gives 0 with ovf=0.
- Requesters must hold valid and data stable until ready. A valid drop without a grant is legal; that request is simply not served.
- The RR pointer only advances on a grant. A single persistent requester is served every accept opportunity.
- Starvation bound: any held request is granted within N_REQ accept opportunities.
- Reset mid-HOLD discards the pending response. No req_ready pulse is ever issued while rst is asserted.

Decomposition:
- Package twos_comp_pkg:
  - state_t enum {IDLE, HOLD}.
  - Default WIDTH/N_REQ constants.
  - ID width localparam ($clog2 of N_REQ).
  - MOST_NEG constant helper.
- Sub-module rr_arbiter:
  - Parameterised on N_REQ.
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant, encoded index, any-grant.
  - Purely combinational.
- Negation (~x+1) and ovf detect stay inline in twos_comp_share_ctrl, registered into the response register.

Test Plan:
- Reset check: assert rst mid-cycle → all outputs 0 immediately. req_valid=4'hF during reset → req_ready=0.
- Single request: requester 2 sends 8'h05 with resp_ready=1 → req_ready=4'b0100 that cycle; next cycle resp_valid=1, resp_data=8'hFB, resp_id=2, resp_ovf=0; conv_count=1.
- Fairness: all four valid continuously with data 8'h01, 8'h02, 8'h03, 8'h04, resp_ready=1 → resp_id sequence 0,1,2,3,0, one per cycle; resp_data FF, FE, FD, FC.
- Backpressure: resp_ready=0 for 3 cycles while HOLD with requests pending → req_ready=0 and resp fields stable. On resp_ready=1, the next grant occurs the same cycle and the new result appears the following cycle.
- Boundaries: operand 8'h80 → resp_data=8'h80, ovf=1. Operand 8'h00 → 8'h00, ovf=0. Operand 8'h7F → 8'h81, ovf=0.
- Reset during HOLD with resp_ready=0 → resp_valid drops asynchronously. After release with requester 3 valid → requester 0-priority pointer restored and requester 3 granted; conv_count restarted from 0.

Source files
------------

// File: rtl/twos_comp_share_ctrl_pkg.sv
// Shared types and constants for the shared two's-complement negation block.
//   state_t   : response-channel FSM state (IDLE: no result held, HOLD: result held)
//   DEF_*     : default parameter values for the top level
//   most_neg  : bit pattern of the most-negative value for a given width
package twos_comp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_ID_W  = $clog2(DEF_N_REQ);

  // Returns a 64-bit word whose low 'width' bits hold 1 followed by zeros.
  function automatic logic [63:0] most_neg(input int unsigned width);
    logic [63:0] r;
    r            = '0;
    r[width - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/twos_comp_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector
//   ptr_i : highest-priority index for this cycle
//   en_i  : when low, no grant is produced
//   gnt_o : one-hot grant
//   idx_o : encoded index of the granted requester
//   any_o : a grant was produced
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  input  logic                     en_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     any_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  always_comb begin
    int unsigned j;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    // Scan from ptr upward with wrap; the first valid request wins.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = (32'(ptr_i) + i) % N_REQ;
      if (en_i && !found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
        found    = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/twos_comp_share_ctrl.sv
// Shares one two's-complement negation unit among N_REQ requesters.
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester request valid
//   req_data   : per-requester operand
//   req_ready  : per-requester accept (one-hot or zero, combinational)
//   resp_valid : registered response valid
//   resp_ready : response consumer ready
//   resp_data  : ~x+1 of the accepted operand
//   resp_id    : index of the served requester
//   resp_ovf   : operand was the most-negative value
//   conv_count : saturating count of consumed responses
module twos_comp_share_ctrl
  import twos_comp_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [WIDTH-1:0]         req_data [N_REQ],
  output logic [N_REQ-1:0]         req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic                     resp_ovf,
  output logic [CNT_W-1:0]         conv_count
);

  localparam int unsigned      ID_W      = $clog2(N_REQ);
  localparam logic [63:0]      MN_W64    = most_neg(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG  = MN_W64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q,   ptr_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [ID_W-1:0]    id_q,    id_d;
  logic               ovf_q,   ovf_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic               accept_ok;
  logic               arb_en;
  logic [N_REQ-1:0]   gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_gnt;
  logic [WIDTH-1:0]   sel_data;
  logic [WIDTH-1:0]   neg_data;

  always_comb begin
    accept_ok = (state_q == IDLE) || resp_ready;
    // Gating with rst keeps req_ready low for the whole reset window.
    arb_en    = accept_ok && !rst;
  end

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any_gnt)
  );

  assign req_ready  = gnt;
  assign resp_valid = (state_q == HOLD);
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign resp_ovf   = ovf_q;
  assign conv_count = cnt_q;

  always_comb begin
    sel_data = req_data[gnt_idx];
    neg_data = ~sel_data + ONE;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    if ((state_q == HOLD) && resp_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (any_gnt) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (resp_ready && !any_gnt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // any_gnt already implies accept_ok, so a grant always loads the result.
    if (any_gnt) begin
      data_d = neg_data;
      id_d   = gnt_idx;
      ovf_d  = (sel_data == MOST_NEG);
      ptr_d  = (gnt_idx == LAST_ID) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_twos_comp_share_ctrl.sv
module tb_twos_comp_share_ctrl;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [W-1:0]   req_data [N];
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [W-1:0]   resp_data;
  logic [1:0]     resp_id;
  logic           resp_ovf;
  logic [CW-1:0]  conv_count;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  bit m_busy;
  int m_data, m_id, m_ovf, m_ptr, m_cnt;
  bit last_acc;
  logic [N-1:0] exp_gnt, act_gnt;

  twos_comp_share_ctrl #(
    .WIDTH (W),
    .N_REQ (N),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ovf   (resp_ovf),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  function automatic int winner(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_data = 0; m_id = 0; m_ovf = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // Apply one cycle of inputs, capture the combinational grant, clock, advance model.
  task automatic advance(input logic [N-1:0] v, input bit rr);
    int w;
    req_valid  = v;
    resp_ready = rr;
    #1;
    last_acc = !m_busy || rr;
    w        = last_acc ? winner(v, m_ptr) : -1;
    exp_gnt  = (w >= 0) ? (N'(1) << w) : '0;
    act_gnt  = req_ready;
    @(posedge clk);
    if (m_busy && rr && m_cnt < (1 << CW) - 1) m_cnt++;
    if (w >= 0) begin
      m_data = ((1 << W) - int'(req_data[w])) % (1 << W);
      m_ovf  = (int'(req_data[w]) == (1 << (W - 1))) ? 1 : 0;
      m_id   = w;
      m_busy = 1;
      m_ptr  = (w + 1) % N;
    end else if (m_busy && rr) begin
      m_busy = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    req_valid = '0; resp_ready = 1'b0;
    for (int i = 0; i < N; i++) req_data[i] = '0;
    do_reset();
    req_data[1] = 8'h33;
    advance(4'b0010, 1'b0);
    vectors++;
    if (resp_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", resp_valid); end
    #3 rst = 1'b1;
    req_valid = 4'hF;
    #1;
    vectors++;
    if (resp_valid !== 1'b0 || resp_data !== 8'h00 || resp_id !== 2'd0 || resp_ovf !== 1'b0 || conv_count !== '0) begin
      errors++;
      $display("FAIL rst_async_outputs: got v=%b d=%h id=%0d ovf=%b cnt=%0d want all zero",
               resp_valid, resp_data, resp_id, resp_ovf, conv_count);
    end
    vectors++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    @(posedge clk);
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready_edge: got %b want 0000", req_ready); end
    rst = 1'b0;
    req_valid = '0;
    model_reset();
  endtask

  task automatic test_single();
    req_data[2] = 8'h05;
    advance(4'b0100, 1'b1);
    vectors++;
    if (act_gnt !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", act_gnt); end
    vectors++;
    if (resp_valid !== 1'b1 || resp_data !== 8'hFB || resp_id !== 2'd2 || resp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: got v=%b d=%h id=%0d ovf=%b want v=1 d=fb id=2 ovf=0",
               resp_valid, resp_data, resp_id, resp_ovf);
    end
    advance(4'b0000, 1'b1);
    vectors++;
    if (conv_count !== 4'd1 || resp_valid !== 1'b0 || resp_data !== 8'hFB) begin
      errors++;
      $display("FAIL single_consume: got cnt=%0d v=%b d=%h want cnt=1 v=0 d=fb", conv_count, resp_valid, resp_data);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] ids [5];
    logic [7:0] dat [5];
    ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    dat = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFF};
    do_reset();
    for (int i = 0; i < N; i++) req_data[i] = 8'(i + 1);
    for (int k = 0; k < 5; k++) begin
      advance(4'hF, 1'b1);
      vectors++;
      if (act_gnt !== (4'b0001 << ids[k])) begin
        errors++; $display("FAIL fair_grant[%0d]: got %b want %b", k, act_gnt, 4'b0001 << ids[k]);
      end
      vectors++;
      if (resp_valid !== 1'b1 || resp_id !== ids[k] || resp_data !== dat[k]) begin
        errors++;
        $display("FAIL fair_resp[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                 k, resp_valid, resp_id, resp_data, ids[k], dat[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] sd;
    logic [1:0] sid;
    logic       sovf;
    advance(4'b0000, 1'b1);
    for (int i = 0; i < N; i++) req_data[i] = 8'($urandom);
    advance(4'hF, 1'b1);
    sd = resp_data; sid = resp_id; sovf = resp_ovf;
    vectors++;
    if (resp_data !== m_data[7:0] || resp_id !== m_id[1:0]) begin
      errors++; $display("FAIL bp_first: got d=%h id=%0d want d=%h id=%0d", resp_data, resp_id, m_data[7:0], m_id[1:0]);
    end
    for (int k = 0; k < 3; k++) begin
      advance(4'hF, 1'b0);
      vectors++;
      if (act_gnt !== 4'b0000) begin errors++; $display("FAIL bp_no_grant[%0d]: got %b want 0000", k, act_gnt); end
      vectors++;
      if (resp_valid !== 1'b1 || resp_data !== sd || resp_id !== sid || resp_ovf !== sovf) begin
        errors++;
        $display("FAIL bp_stable[%0d]: got v=%b d=%h id=%0d ovf=%b want v=1 d=%h id=%0d ovf=%b",
                 k, resp_valid, resp_data, resp_id, resp_ovf, sd, sid, sovf);
      end
    end
    advance(4'hF, 1'b1);
    vectors++;
    if (act_gnt !== exp_gnt || act_gnt === 4'b0000) begin
      errors++; $display("FAIL bp_release_grant: got %b want %b", act_gnt, exp_gnt);
    end
    vectors++;
    if (resp_id !== m_id[1:0] || resp_data !== m_data[7:0] || conv_count !== m_cnt[CW-1:0]) begin
      errors++;
      $display("FAIL bp_release_resp: got id=%0d d=%h cnt=%0d want id=%0d d=%h cnt=%0d",
               resp_id, resp_data, conv_count, m_id[1:0], m_data[7:0], m_cnt[CW-1:0]);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] ops [3];
    logic [7:0] res [3];
    logic       ovf [3];
    ops = '{8'h80, 8'h00, 8'h7F};
    res = '{8'h80, 8'h00, 8'h81};
    ovf = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      req_data[0] = ops[k];
      advance(4'b0001, 1'b1);
      vectors++;
      if (resp_valid !== 1'b1 || resp_data !== res[k] || resp_ovf !== ovf[k] || resp_id !== 2'd0) begin
        errors++;
        $display("FAIL boundary[%h]: got v=%b d=%h ovf=%b id=%0d want v=1 d=%h ovf=%b id=0",
                 ops[k], resp_valid, resp_data, resp_ovf, resp_id, res[k], ovf[k]);
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 20; k++) begin
      req_data[0] = 8'($urandom);
      advance(4'b0001, 1'b1);
      vectors++;
      if (act_gnt !== 4'b0001 || conv_count !== m_cnt[CW-1:0]) begin
        errors++;
        $display("FAIL sat_step[%0d]: got gnt=%b cnt=%0d want gnt=0001 cnt=%0d", k, act_gnt, conv_count, m_cnt[CW-1:0]);
      end
    end
    vectors++;
    if (conv_count !== 4'hF) begin errors++; $display("FAIL sat_final: got %0d want 15", conv_count); end
  endtask

  task automatic test_reset_hold();
    advance(4'b0000, 1'b1);
    req_data[1] = 8'h10;
    advance(4'b0010, 1'b1);
    advance(4'b0000, 1'b0);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (resp_valid !== 1'b0 || conv_count !== '0) begin
      errors++; $display("FAIL rsthold_async: got v=%b cnt=%0d want v=0 cnt=0", resp_valid, conv_count);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    req_data[0] = 8'h02; req_data[3] = 8'h09;
    advance(4'b1001, 1'b1);
    vectors++;
    if (act_gnt !== 4'b0001) begin errors++; $display("FAIL rsthold_ptr: got %b want 0001", act_gnt); end
    advance(4'b1000, 1'b1);
    vectors++;
    if (act_gnt !== 4'b1000) begin errors++; $display("FAIL rsthold_req3: got %b want 1000", act_gnt); end
    vectors++;
    if (resp_id !== 2'd3 || resp_data !== 8'hF7 || conv_count !== 4'd1) begin
      errors++;
      $display("FAIL rsthold_resp: got id=%0d d=%h cnt=%0d want id=3 d=f7 cnt=1", resp_id, resp_data, conv_count);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    int waitc [N];
    bit rr;
    v = '0;
    for (int r = 0; r < N; r++) waitc[r] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < N; r++) begin
        if (!v[r]) begin
          if ($urandom_range(0, 2) == 0) begin
            v[r] = 1'b1; req_data[r] = 8'($urandom); waitc[r] = 0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          v[r] = 1'b0;
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      advance(v, rr);
      vectors++;
      if (act_gnt !== exp_gnt) begin errors++; $display("FAIL rand_grant[%0d]: got %b want %b", cyc, act_gnt, exp_gnt); end
      vectors++;
      if (resp_valid !== m_busy || resp_data !== m_data[7:0] || resp_id !== m_id[1:0] ||
          resp_ovf !== m_ovf[0] || conv_count !== m_cnt[CW-1:0]) begin
        errors++;
        $display("FAIL rand_resp[%0d]: got v=%b d=%h id=%0d ovf=%b cnt=%0d want v=%b d=%h id=%0d ovf=%b cnt=%0d",
                 cyc, resp_valid, resp_data, resp_id, resp_ovf, conv_count,
                 m_busy, m_data[7:0], m_id[1:0], m_ovf[0], m_cnt[CW-1:0]);
      end
      for (int r = 0; r < N; r++) begin
        if (v[r] && act_gnt[r]) begin
          v[r] = 1'b0;
        end else if (v[r] && last_acc) begin
          waitc[r]++;
          vectors++;
          if (waitc[r] >= N) begin
            errors++; $display("FAIL rand_starve[%0d]: req %0d waited %0d want <%0d", cyc, r, waitc[r], N);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_boundaries();
    test_saturation();
    test_reset_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
